// File: rtl/bptt_dgate_sched_pkg.sv
// Shared definitions for the layer-2 BPTT delta-gate scheduler: default
// layer-2 geometry, FSM state encoding and a width helper.
package bptt_dgate_sched_pkg;

    localparam int L2_ADDR_WIDTH = 12;
    localparam int L2_NUM_CELL   = 8;
    localparam int L2_TIMESTEP   = 7;
    localparam int L2_PIPE_DELAY = 4;
    localparam int L2_PAUSE_LEN  = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_e;

    // Bits needed to hold 0..value-1, never less than one bit.
    function automatic int clog2_min1(input int value);
        int width;
        width = 1;
        while ((64'd1 << width) < 64'(value)) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/bptt_dgate_sched_delay_line.sv
// Fixed-depth shift register with asynchronous clear; carries the issued
// read strobe/address forward to the write-back side.
module bptt_dgate_sched_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

    generate
        if (DEPTH == 1) begin : g_single
            // Single stage: plain register.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe[0] <= i_d;
                end
            end
        end else begin : g_multi
            // Multi stage: shift in at index 0, oldest entry at DEPTH-1.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= {r_pipe[DEPTH-2:0], i_d};
                end
            end
        end
    endgenerate

    assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/bptt_dgate_sched.sv
// Layer-2 BPTT delta-gate scheduler: walks timesteps in reverse and cells
// forward, issuing read addresses and delayed write-back strobes.
module bptt_dgate_sched
    import bptt_dgate_sched_pkg::*;
#(
    parameter int ADDR_WIDTH = L2_ADDR_WIDTH,
    parameter int NUM_CELL   = L2_NUM_CELL,
    parameter int TIMESTEP   = L2_TIMESTEP,
    parameter int PIPE_DELAY = L2_PIPE_DELAY,
    parameter int PAUSE_LEN  = L2_PAUSE_LEN
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_en,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    output logic                  o_rd_vld,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic                  o_wr_en,
    output logic                  o_first_t,
    output logic                  o_t_start,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int T_W     = clog2_min1(TIMESTEP);
    localparam int CELL_W  = clog2_min1(NUM_CELL);
    localparam int CNT_MAX = (PAUSE_LEN > PIPE_DELAY) ? PAUSE_LEN : PIPE_DELAY;
    localparam int CNT_W   = clog2_min1(CNT_MAX);

    localparam logic [T_W-1:0]        T_FIRST    = T_W'(TIMESTEP - 1);
    localparam logic [CELL_W-1:0]     CELL_LAST  = CELL_W'(NUM_CELL - 1);
    localparam logic [CNT_W-1:0]      PAUSE_LAST = CNT_W'((PAUSE_LEN > 0) ? PAUSE_LEN - 1 : 0);
    localparam logic [CNT_W-1:0]      DRAIN_LAST = CNT_W'(PIPE_DELAY - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE_FIRST = ADDR_WIDTH'((TIMESTEP - 1) * NUM_CELL);
    localparam logic [ADDR_WIDTH-1:0] BASE_STEP  = ADDR_WIDTH'(NUM_CELL);
    localparam logic                  SKIP_PAUSE = (PAUSE_LEN == 0);

    if (64'(TIMESTEP) * 64'(NUM_CELL) > (64'd1 << ADDR_WIDTH)) begin : g_addr_overflow
        $error("bptt_dgate_sched: TIMESTEP*NUM_CELL-1 does not fit ADDR_WIDTH");
    end
    if (PIPE_DELAY < 1) begin : g_bad_delay
        $error("bptt_dgate_sched: PIPE_DELAY must be at least 1");
    end

    sched_state_e          r_state;
    sched_state_e          w_state_nxt;
    logic [T_W-1:0]        r_t;
    logic [T_W-1:0]        w_t_nxt;
    logic [CELL_W-1:0]     r_cell;
    logic [CELL_W-1:0]     w_cell_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] w_base_nxt;
    logic [ADDR_WIDTH-1:0] w_base_dec;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_rd_vld;
    logic [ADDR_WIDTH:0]   w_dl_d;
    logic [ADDR_WIDTH:0]   w_dl_q;

    // Next timestep's base; the address counter is reloaded from it so no multiplier is needed.
    assign w_base_dec = r_base - BASE_STEP;

    // Next-state and counter update logic.
    always_comb begin
        w_state_nxt = r_state;
        w_t_nxt     = r_t;
        w_cell_nxt  = r_cell;
        w_cnt_nxt   = r_cnt;
        w_base_nxt  = r_base;
        w_addr_nxt  = r_rd_addr;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_RUN;
                    w_t_nxt     = T_FIRST;
                    w_cell_nxt  = '0;
                    w_base_nxt  = BASE_FIRST;
                    w_addr_nxt  = BASE_FIRST;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!i_en) begin
                    w_state_nxt = ST_RUN;
                end else if (r_cell != CELL_LAST) begin
                    w_cell_nxt = r_cell + CELL_W'(1);
                    w_addr_nxt = r_rd_addr + ADDR_WIDTH'(1);
                end else if (r_t == '0) begin
                    w_state_nxt = ST_DRAIN;
                    w_cnt_nxt   = '0;
                end else if (SKIP_PAUSE) begin
                    w_t_nxt    = r_t - T_W'(1);
                    w_cell_nxt = '0;
                    w_base_nxt = w_base_dec;
                    w_addr_nxt = w_base_dec;
                end else begin
                    w_state_nxt = ST_PAUSE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_PAUSE: begin
                if (r_cnt == PAUSE_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_t_nxt     = r_t - T_W'(1);
                    w_cell_nxt  = '0;
                    w_base_nxt  = w_base_dec;
                    w_addr_nxt  = w_base_dec;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (r_cnt == DRAIN_LAST) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered status outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_t       <= '0;
            r_cell    <= '0;
            r_cnt     <= '0;
            r_base    <= '0;
            r_rd_addr <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_t       <= w_t_nxt;
            r_cell    <= w_cell_nxt;
            r_cnt     <= w_cnt_nxt;
            r_base    <= w_base_nxt;
            r_rd_addr <= w_addr_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_done    <= (w_state_nxt == ST_DONE);
        end
    end

    // en gates the issue in the same cycle so the fsm can stall without a bubble of latency.
    assign w_rd_vld  = (r_state == ST_RUN) && i_en;
    assign o_rd_vld  = w_rd_vld;
    assign o_rd_addr = r_rd_addr;
    assign o_first_t = w_rd_vld && (r_t == T_FIRST);
    assign o_t_start = w_rd_vld && (r_cell == '0);
    assign o_busy    = r_busy;
    assign o_done    = r_done;

    assign w_dl_d = {w_rd_vld, r_rd_addr};

    bptt_dgate_sched_delay_line #(
        .WIDTH (ADDR_WIDTH + 1),
        .DEPTH (PIPE_DELAY)
    ) u_delay_line (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (w_dl_d),
        .o_q     (w_dl_q)
    );

    assign o_wr_en   = w_dl_q[ADDR_WIDTH];
    assign o_wr_addr = w_dl_q[ADDR_WIDTH-1:0];

endmodule
